// File: rtl/fetch_pkg.sv
// Shared widths, defaults and the queue entry type for the fetch stage.
package fetch_pkg;

  localparam int DEF_PC_W        = 12;
  localparam int DEF_INSTR_W     = 16;
  localparam int DEF_QUEUE_DEPTH = 4;
  localparam logic [DEF_PC_W-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order prefetch FIFO: head visible combinationally, one cycle from push to head.
// Flush empties it and takes priority over push/pop; the caller's credit logic prevents overflow.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEF_QUEUE_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC generator, credit-limited requests, discard of stale responses after redirect.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W        = DEF_PC_W,
  parameter int              INSTR_W     = DEF_INSTR_W,
  parameter int              QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [PC_W-1:0]    mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int            CW        = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            req_fire;
  logic            rsp_keep;
  entry_t          rsp_entry;
  entry_t          head_entry;
  entry_t          out_entry;

  // Every buffered or outstanding instruction holds a slot, so a response always fits.
  assign mem_req_valid = !reset && !redirect_valid &&
                         (({1'b0, q_count} + {1'b0, inflight}) < DEPTH_LIM);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign q_empty   = (q_count == '0);
  assign rsp_entry = '{pc: rsp_pc, instr: mem_rsp_data};
  assign rsp_keep  = !reset && !redirect_valid && mem_rsp_valid && (discard == '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_keep && q_empty;
  assign out_valid = !q_empty || bypass;
  assign out_entry = q_empty ? rsp_entry : head_entry;
  assign q_push    = rsp_keep && !(bypass && out_ready);
`else
  assign out_valid = !q_empty;
  assign out_entry = head_entry;
  assign q_push    = rsp_keep;
`endif

  assign q_pop     = !q_empty && out_ready && !redirect_valid;
  assign out_instr = out_valid ? out_entry.instr : '0;
  assign out_pc    = out_valid ? out_entry.pc    : '0;

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (q_push),
    .push_entry (rsp_entry),
    .pop        (q_pop),
    .head_entry (head_entry),
    .count      (q_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding is stale, including anything already marked for discard.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      inflight <= inflight - CW'(mem_rsp_valid);
      discard  <= inflight - CW'(mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_W'(1);
      if (rsp_keep) rsp_pc   <= rsp_pc + PC_W'(1);
      inflight <= inflight + CW'(req_fire) - CW'(mem_rsp_valid);
      if (mem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  a_no_rsp_when_full : assert property (@(posedge clk) disable iff (reset)
    !(mem_rsp_valid && (q_count == CW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit with a latency-programmable memory model.
// Covers streaming, stall/resume, redirects with stale responses, PC wrap, async reset, FETCH_BYPASS_EN timing.
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [11:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [15:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [11:0] out_pc;

  fetch_prefetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] instr;
  } exp_t;

  typedef struct {
    int          due;
    logic [11:0] addr;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    mem_lat = 1;
  int    last_due = 0;
  logic  force_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return {4'h5, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [11:0] pc);
    exp_q.push_back('{pc: pc, instr: mem_word(pc)});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic redirect(input logic [11:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    next_cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      next_cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory: in-order responses, one per cycle, mem_lat cycles after acceptance.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        pend_q.delete();
        last_due      = 0;
        mem_rsp_valid = 1'b0;
      end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
      end
      @(negedge clk);
      if (!reset && mem_req_valid && mem_req_ready) begin
        pend_t p;
        p.due  = (cyc + mem_lat > last_due) ? cyc + mem_lat : last_due + 1;
        p.addr = mem_req_addr;
        last_due = p.due;
        pend_q.push_back(p);
      end
    end
  end

  // Decode consumes only what the scoreboard still expects, plus forced cycles.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = force_ready || (exp_q.size() != 0);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !redirect_valid && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %0h, required no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    int  fires;
    bit  seen;
    logic [11:0] wrap_tbl [3];
    wrap_tbl = '{12'hFFE, 12'hFFF, 12'h000};

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b1;
    #2;
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_req_addr", mem_req_addr, 0);
    settle(2);

    // Streaming from RESET_PC, one instruction per cycle.
    for (int i = 0; i < 8; i++) push_exp(12'(i));
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stream_req_valid", mem_req_valid, 1);
      check("stream_req_addr", mem_req_addr, i);
      if (i >= 2) check("stream_out_valid", out_valid, 1);
      next_cycle();
    end
    wait_drain("stream");

    // Stall: only QUEUE_DEPTH requests, then resume at the next address.
    settle(4);
    redirect(12'h000);
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        check("stall_addr", mem_req_addr, fires);
        fires++;
      end
      next_cycle();
    end
    check("stall_fires", fires, 4);
    @(negedge clk);
    check("stall_req_valid", mem_req_valid, 0);
    next_cycle();
    for (int i = 0; i < 8; i++) push_exp(12'(i));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        check("resume_addr", mem_req_addr, 4);
        seen = 1'b1;
      end
      next_cycle();
    end
    check("resume_seen", seen, 1);
    wait_drain("stall");

    // Redirect with two requests outstanding at 3-cycle latency.
    settle(6);
    mem_lat = 3;
    redirect(12'h050);
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h100;
    @(negedge clk);
    check("redir_req_valid", mem_req_valid, 0);
    next_cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(12'(12'h100 + i));
    @(negedge clk);
    check("redir_q_empty", out_valid, 0);
    check("redir_first_req", mem_req_valid, 1);
    check("redir_first_addr", mem_req_addr, 12'h100);
    wait_drain("redirect");

    // Redirect coinciding with a response and a pop.
    settle(8);
    redirect(12'h200);
    settle(4);
    redirect_valid = 1'b1;
    redirect_pc    = 12'h300;
    force_ready    = 1'b1;
    @(negedge clk);
    check("coll_out_valid", out_valid, 1);
    check("coll_req_valid", mem_req_valid, 0);
    next_cycle();
    redirect_valid = 1'b0;
    force_ready    = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(12'(12'h300 + i));
    @(negedge clk);
    check("coll_q_empty", out_valid, 0);
    check("coll_req_valid_after", mem_req_valid, 1);
    check("coll_req_addr_after", mem_req_addr, 12'h300);
    wait_drain("collide");

    // PC wrap.
    settle(8);
    mem_lat = 1;
    settle(4);
    redirect(12'hFFE);
    for (int i = 0; i < 4; i++) push_exp(12'(12'hFFE + i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wrap_req_valid", mem_req_valid, 1);
      check("wrap_req_addr", mem_req_addr, wrap_tbl[i]);
      next_cycle();
    end
    wait_drain("wrap");

    // Asynchronous reset in mid-stream.
    settle(4);
    redirect(12'h080);
    push_exp(12'h080);
    push_exp(12'h081);
    settle(3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("arst_req_valid", mem_req_valid, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_pc", out_pc, 0);
    check("arst_out_instr", out_instr, 0);
    check("arst_req_addr", mem_req_addr, 0);
    settle(3);
    for (int i = 0; i < 4; i++) push_exp(12'(i));
    reset = 1'b0;
    @(negedge clk);
    check("arst_restart_valid", mem_req_valid, 1);
    check("arst_restart_addr", mem_req_addr, 0);
    wait_drain("arst");

    // First-response timing with an empty queue.
    settle(6);
    redirect(12'h040);
    push_exp(12'h040);
    next_cycle();
    @(negedge clk);
`ifdef FETCH_BYPASS_EN
    check("bypass_same_cycle", out_valid, 1);
`else
    check("nobypass_same_cycle", out_valid, 0);
`endif
    next_cycle();
    @(negedge clk);
    check("first_rsp_next_cycle", out_valid, 1);
    wait_drain("bypass");

    settle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised next-generation fetch stage: PC generator plus in-order prefetch queue with valid/ready handshakes to instruction memory and decode.
- Keeps up to QUEUE_DEPTH instructions buffered or in flight.
- Redirects (branch/jump) flush the queue and discard stale in-flight responses.
- Sits between instruction memory and decode.

Parameters:
PC_W, 12, program counter / memory word-address width
INSTR_W, 16, instruction width
QUEUE_DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
redirect_valid  in  1  load redirect_pc, flush pipeline
redirect_pc  in  PC_W  redirect target (used directly, no offset)
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  PC_W  fetch address
mem_rsp_valid  in  1  response data valid (in order, latency >=1, always accepted)
mem_rsp_data  in  INSTR_W  returned instruction
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  PC of out_instr

Behaviour:
- Reset: fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, inflight=0, discard=0; mem_req_valid=0, out_valid=0, out_instr=0, out_pc=0.
- Credit: mem_req_valid = !redirect_valid && (count + inflight < QUEUE_DEPTH). Never depends on mem_req_ready. mem_req_addr = fetch_pc.
- Request fire (valid&ready): fetch_pc <= fetch_pc+1 mod 2^PC_W (wraps 0xFFF->0x000 at default); inflight++.
- Response with discard==0: push {rsp_pc, mem_rsp_data}; rsp_pc++ (wraps); inflight--.
- Response with discard>0: dropped; discard--, inflight--.
- Output: out_valid = count!=0; head popped on out_valid&out_ready. Push and pop in the same cycle keep count unchanged. Full queue with response is impossible by credit; assert it.
- Redirect (priority over everything): fetch_pc and rsp_pc <= redirect_pc; queue flushed (count=0; a same-cycle pop is ignored).
  - discard <= inflight minus 1 if a response arrives that cycle (that response is itself dropped).
  - No request is issued that cycle.
  - First new request is issued the next cycle.
- Back-to-back redirects: the later target wins; discard accounting accumulates correctly.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight responses arriving after reset release are not dropped. The memory must be reset alongside this block.
- Steady state with mem_req_ready=1 and 1-cycle latency: one instruction per cycle.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty and an accepted response arrives, out_valid, out_instr and out_pc reflect it combinationally in the same cycle.
  - If out_ready=1, it is consumed without being pushed.
  - Otherwise it is pushed.
- Undefined: the earliest out_valid is the cycle after the response.

Decomposition:
- Package fetch_pkg: PC_W/INSTR_W default localparams; typedef fetch_entry_t {pc, instr}; RESET_PC default.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with flush input, count output, push/pop.
- fetch_prefetch_unit holds the PC, credit, inflight and discard logic.

Test Plan:
- Reset, mem_req_ready=1, 1-cycle latency, out_ready=1 -> mem_req_addr 0,1,2...; out_pc 0,1,2 on consecutive cycles after fill; out_instr matches memory.
- out_ready=0 -> exactly QUEUE_DEPTH=4 requests (addr 0-3), then mem_req_valid=0. Release -> resumes at addr 4, no loss or duplication.
- Two requests in flight (3-cycle latency), redirect_pc=0x100 -> queue empty next cycle; both stale responses dropped; first out_pc=0x100 with the instruction from 0x100.
- Redirect in the same cycle as a response and a pop -> that response dropped, discard=inflight-1, no request issued that cycle.
- redirect_pc=0xFFE, free-running -> addresses 0xFFE, 0xFFF, 0x000; out_pc wraps identically.
- Async reset mid-stream -> outputs to reset values without a clock edge; fetch restarts at RESET_PC.
- FETCH_BYPASS_EN on: empty queue, response with out_ready=1 -> out_valid in the same cycle; off: the next cycle.
